// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR encrypt/decrypt pipeline.
package lfsr_pkg;

  localparam int         ENC_BASE_ADDR = 64;
  localparam int         NUM_CAND      = 6;
  localparam logic [7:0] PREAMBLE      = 8'h5F;
  localparam logic [1:0] PRE_HI        = 2'b01;
  localparam logic [5:0] SEED_MASK     = 6'h1F;

  localparam logic [5:0] CAND_TAPS [0:NUM_CAND-1] = '{
    6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEED,
    ST_LOAD,
    ST_CHECK,
    ST_REWIND,
    ST_SKIP,
    ST_COPY,
    ST_DONE,
    ST_FAIL
  } state_t;

  // One LFSR advance: shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] taps);
    return {s[4:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_decrypt_if.sv
// dat_mem port bundle shared by the encrypt and decrypt stages.
interface lfsr_decrypt_if;
  logic [7:0] data_out;
  logic [7:0] raddr;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic       write_en;

  modport master (
    input  data_out,
    output raddr,
    output waddr,
    output data_in,
    output write_en
  );

  modport slave (
    output data_out,
    input  raddr,
    input  waddr,
    input  data_in,
    input  write_en
  );
endinterface

// File: rtl/lfsr6.sv
// 6-bit Fibonacci-style LFSR with loadable taps and state.
module lfsr6
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       init,
  input  logic [5:0] taps,
  input  logic [5:0] start,
  output logic [5:0] state
);

  logic [5:0] taps_r;

  // init wins over en so a reload never also advances.
  always_ff @(posedge clk) begin
    if (init) begin
      taps_r <= taps;
      state  <= start;
    end else if (en) begin
      state <= lfsr_next(state, taps_r);
    end
  end

endmodule

// File: rtl/lfsr_decrypt.sv
// Recovers the LFSR taps from the '_' preamble, then writes the decoded plaintext to dat_mem[0..].
module lfsr_decrypt
  import lfsr_pkg::*;
#(
  parameter int ENC_BASE  = ENC_BASE_ADDR,
  parameter int ENC_LEN   = 64,
  parameter int CHECK_LEN = 6
)
(
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  start,
  lfsr_decrypt_if.master        mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [5:0]            taps_found,
  output state_t                dbg_state
);

  localparam int RD_W = $clog2(ENC_LEN);
  localparam int K_W  = $clog2(CHECK_LEN + 1);

  // Handshake: start is a one-cycle request honoured only in IDLE/DONE/FAIL;
  // busy covers SEED..COPY; done (and fail) hold until the next accepted start.
  state_t          state_r, state_nx;
  logic [2:0]      cand;
  logic [K_W-1:0]  k;
  logic [RD_W-1:0] rd, wr;
  logic [5:0]      seed;
  logic [5:0]      lfsr_q;
  logic [5:0]      lfsr_pred;
  logic [7:0]      decoded;
  logic            check_ok, rd_last, k_last, cand_last;
  logic            lfsr_en, lfsr_init;

  lfsr6 u_lfsr (
    .clk   (clk),
    .en    (lfsr_en),
    .init  (lfsr_init),
    .taps  (CAND_TAPS[cand]),
    .start (seed),
    .state (lfsr_q)
  );

  assign decoded   = mem.data_out ^ {2'b00, lfsr_q};
  assign lfsr_pred = lfsr_next(lfsr_q, CAND_TAPS[cand]);
  assign check_ok  = (mem.data_out[7:6] == PRE_HI) &&
                     ((mem.data_out[5:0] ^ SEED_MASK) == lfsr_pred);
  assign rd_last   = (rd == RD_W'(ENC_LEN - 1));
  assign k_last    = (k == K_W'(CHECK_LEN));
  assign cand_last = (cand == 3'(NUM_CAND - 1));

  assign busy      = !(state_r inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign done      = (state_r == ST_DONE) || (state_r == ST_FAIL);
  assign fail      = (state_r == ST_FAIL);
  assign dbg_state = state_r;

  always_comb begin
    state_nx     = state_r;
    mem.raddr    = 8'h00;
    mem.waddr    = 8'h00;
    mem.data_in  = 8'h00;
    mem.write_en = 1'b0;
    lfsr_en      = 1'b0;
    lfsr_init    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_nx = ST_SEED;
      end
      ST_SEED: begin
        mem.raddr = 8'(ENC_BASE);
        state_nx  = ST_LOAD;
      end
      ST_LOAD: begin
        lfsr_init = 1'b1;
        state_nx  = ST_CHECK;
      end
      ST_CHECK: begin
        mem.raddr = 8'(ENC_BASE) + 8'(k);
        lfsr_en   = 1'b1;
        if (!check_ok)   state_nx = cand_last ? ST_FAIL : ST_LOAD;
        else if (k_last) state_nx = ST_REWIND;
      end
      ST_REWIND: begin
        lfsr_init = 1'b1;
        state_nx  = ST_SKIP;
      end
      ST_SKIP: begin
        mem.raddr = 8'(ENC_BASE) + 8'(rd);
        lfsr_en   = 1'b1;
        // First non-preamble byte is already plaintext: write it on the way out.
        if (decoded != PREAMBLE) begin
          mem.write_en = 1'b1;
          mem.waddr    = 8'(wr);
          mem.data_in  = decoded;
          state_nx     = rd_last ? ST_DONE : ST_COPY;
        end else if (rd_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_COPY: begin
        mem.raddr    = 8'(ENC_BASE) + 8'(rd);
        mem.write_en = 1'b1;
        mem.waddr    = 8'(wr);
        mem.data_in  = decoded;
        lfsr_en      = 1'b1;
        if (rd_last) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_r    <= ST_IDLE;
      cand       <= 3'd0;
      k          <= '0;
      rd         <= '0;
      wr         <= '0;
      seed       <= 6'h00;
      taps_found <= 6'h00;
    end else begin
      state_r <= state_nx;
      case (state_r)
        ST_SEED: begin
          seed <= mem.data_out[5:0] ^ SEED_MASK;
          cand <= 3'd0;
        end
        ST_LOAD: k <= K_W'(1);
        ST_CHECK: begin
          if (check_ok)        k    <= k + K_W'(1);
          else if (!cand_last) cand <= cand + 3'd1;
        end
        ST_REWIND: begin
          taps_found <= CAND_TAPS[cand];
          rd         <= '0;
          wr         <= '0;
        end
        ST_SKIP: begin
          rd <= rd + RD_W'(1);
          if (decoded != PREAMBLE) wr <= wr + RD_W'(1);
        end
        ST_COPY: begin
          rd <= rd + RD_W'(1);
          wr <= wr + RD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Self-checking bench for lfsr_decrypt: encrypts messages in a behavioural model and checks recovery.
module tb_lfsr_decrypt;
  import lfsr_pkg::*;

  localparam int BASE      = 64;
  localparam int ENC_LEN   = 64;
  localparam int CHECK_LEN = 6;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [5:0] taps_found;
  state_t     dbg_state;

  lfsr_decrypt_if bus ();

  lfsr_decrypt #(.ENC_BASE(BASE), .ENC_LEN(ENC_LEN), .CHECK_LEN(CHECK_LEN)) dut (
    .clk        (clk),
    .init_n     (init_n),
    .start      (start),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .taps_found (taps_found),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- dat_mem model ----------------
  logic [7:0] dat_mem  [0:255];
  logic [7:0] load_img [0:255];
  logic       mem_load = 1'b0;

  assign bus.data_out = dat_mem[bus.raddr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) dat_mem[i] <= load_img[i];
    end else if (bus.write_en) begin
      dat_mem[bus.waddr] <= bus.data_in;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected writes, {waddr, data_in}, in order.
  logic [15:0] exp_q [$];

  always @(negedge clk) begin
    if (init_n && bus.write_en) begin
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      check("write_in_skip_or_copy", 32'((dbg_state == ST_SKIP) || (dbg_state == ST_COPY)), 32'd1);
      if (exp_q.size() > 0) check("write_addr_data", {16'h0, bus.waddr, bus.data_in}, {16'h0, exp_q.pop_front()});
    end
  end

  // ---------------- reference model ----------------
  logic [5:0] cand_list [0:5] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
  logic [7:0] msg   [0:63];
  int         msg_len;
  logic [7:0] enc   [0:63];
  logic [7:0] fill_b;
  logic [7:0] exp_img [0:63];
  logic [15:0] model_wr [$];
  int         exp_lat;
  logic       exp_fail;
  logic [5:0] exp_taps;

  function automatic logic [5:0] adv(input logic [5:0] s, input logic [5:0] t);
    int fb;
    fb = $countones(s & t) % 2;
    return 6'(((int'(s) * 2) % 64) + fb);
  endfunction

  // Derive everything the DUT should do from the encrypted block alone.
  task automatic model_from_enc();
    logic [5:0] seed, cs;
    int winner, mk, first, n;
    logic [7:0] dec [0:63];
    seed    = enc[0][5:0] ^ 6'h1F;
    winner  = -1;
    exp_lat = 1;
    for (int c = 0; c < 6 && winner < 0; c++) begin
      cs = seed;
      mk = 0;
      for (int kk = 1; kk <= CHECK_LEN && mk == 0; kk++) begin
        cs = adv(cs, cand_list[c]);
        if (enc[kk][7:6] != 2'b01 || (enc[kk][5:0] ^ 6'h1F) != cs) mk = kk;
      end
      if (mk == 0) begin
        winner  = c;
        exp_lat += 1 + CHECK_LEN + 1 + ENC_LEN;
      end else begin
        exp_lat += 1 + mk;
      end
    end
    exp_fail = (winner < 0);
    exp_taps = exp_fail ? 6'h00 : cand_list[winner];
    model_wr.delete();
    for (int i = 0; i < 64; i++) exp_img[i] = fill_b;
    if (!exp_fail) begin
      cs = seed;
      for (int i = 0; i < 64; i++) begin
        dec[i] = enc[i] ^ {2'b00, cs};
        cs = adv(cs, exp_taps);
      end
      first = 64;
      for (int i = 63; i >= 0; i--) if (dec[i] != 8'h5F) first = i;
      n = 0;
      for (int i = first; i < 64; i++) begin
        exp_img[n] = dec[i];
        model_wr.push_back({8'(n), dec[i]});
        n++;
      end
    end
  endtask

  task automatic encrypt(input int pre_len, input logic [5:0] taps, input logic [5:0] seed);
    logic [5:0] s;
    logic [7:0] p;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      if (i < pre_len)                p = 8'h5F;
      else if (i - pre_len < msg_len) p = msg[i - pre_len];
      else                            p = 8'h20;
      enc[i] = p ^ {2'b00, s};
      s = adv(s, taps);
    end
    fill_b = 8'($urandom_range(0, 255));
    model_from_enc();
  endtask

  task automatic random_msg(input int pre_len);
    msg_len = $urandom_range(8, 64 - pre_len);
    msg[0]  = 8'($urandom_range(65, 90));
    for (int i = 1; i < 64; i++)
      msg[i] = ($urandom_range(0, 4) == 0) ? 8'h5F : 8'($urandom_range(32, 126));
    msg[2] = 8'h5F;
  endtask

  // ---------------- drivers ----------------
  task automatic prepare();
    for (int i = 0; i < 256; i++) load_img[i] = 8'h00;
    for (int i = 0; i < 64; i++) begin
      load_img[i]        = fill_b;
      load_img[BASE + i] = enc[i];
    end
    mem_load = 1'b1;
    @(posedge clk); #1;
    mem_load = 1'b0;
    exp_q.delete();
    foreach (model_wr[i]) exp_q.push_back(model_wr[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one decode; glitch_at >= 0 re-asserts start that many cycles into the run.
  task automatic run_decode(input string tag, input int glitch_at);
    int cycles;
    prepare();
    pulse_start();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    cycles = 0;
    while (!done && cycles < exp_lat + 20) begin
      start = (cycles == glitch_at);
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'(exp_fail));
    if (!exp_fail) check({tag, "_taps_found"}, 32'(taps_found), 32'(exp_taps));
    check({tag, "_writes_outstanding"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_mem%0d", tag, i), 32'(dat_mem[i]), 32'(exp_img[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    string s;
    int    waited;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_fail", 32'(fail), 32'd0);
    check("reset_write_en", 32'(bus.write_en), 32'd0);
    check("reset_taps_found", 32'(taps_found), 32'd0);
    check("reset_raddr", 32'(bus.raddr), 32'd0);
    check("reset_waddr", 32'(bus.waddr), 32'd0);
    check("reset_data_in", 32'(bus.data_in), 32'd0);
    init_n = 1'b1;
    @(posedge clk); #1;

    s = "Mr. Watson, come here. I want to see you.";
    msg_len = s.len();
    for (int i = 0; i < msg_len; i++) msg[i] = s[i];
    encrypt(10, 6'h33, 6'h01);
    run_decode("basic", -1);

    for (int t = 0; t < 6; t++) begin
      random_msg(7);
      encrypt(7, cand_list[t], 6'h2A);
      run_decode($sformatf("sweep%0d", t), -1);
    end

    random_msg(7);
    encrypt(7, cand_list[$urandom_range(0, 5)], 6'($urandom_range(1, 63)));
    run_decode("pre7", -1);
    random_msg(15);
    encrypt(15, cand_list[$urandom_range(0, 5)], 6'($urandom_range(1, 63)));
    run_decode("pre15", -1);

    for (int i = 0; i < 64; i++) enc[i] = 8'h00;
    fill_b = 8'($urandom_range(0, 255));
    model_from_enc();
    check("nomatch_model_latency_bound", 32'(exp_lat <= 6 * (1 + CHECK_LEN) + 2), 32'd1);
    run_decode("nomatch", -1);

    random_msg(9);
    encrypt(9, cand_list[$urandom_range(0, 5)], 6'($urandom_range(1, 63)));
    prepare();
    pulse_start();
    waited = 0;
    while (dbg_state != ST_COPY && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("midrun_reached_copy", 32'(dbg_state), 32'(ST_COPY));
    repeat (3) @(posedge clk);
    #1;
    init_n = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrun_reset_write_en", 32'(bus.write_en), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    init_n = 1'b1;
    @(posedge clk); #1;
    run_decode("after_reset", -1);

    random_msg(8);
    encrypt(8, cand_list[$urandom_range(0, 5)], 6'($urandom_range(1, 63)));
    run_decode("restart_busy", 5);
    run_decode("restart_from_done", -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
